// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard sequencer.
//   state_t  : sequencer state encoding (also exported on the debug port)
//   action_t : what the pipeline does in the current cycle
//   REG_ZERO : architectural $zero, never a real hazard (shared with forwarding)
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        MEM_WAIT   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ACT_NONE   = 2'd0,
        ACT_FREEZE = 2'd1,
        ACT_FLUSH  = 2'd2,
        ACT_STALL  = 2'd3
    } action_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Bundle between the pipeline datapath and the hazard sequencer.
// Handshake: there is no valid/ready pair here; every field is a level that is
// meaningful every cycle. The datapath (master) presents the hazard sources and
// the sequencer (slave) answers combinationally in the same cycle with the
// pipeline-register enables, flushes and bubbles.
//   hazard sources : id_rs, id_rt, id_uses_rt, ex_rt, ex_mem_read, branch_taken,
//                    mem_req, mem_ready, stat_clr
//   controls       : pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
//                    exmem_write, memwb_bubble
//   status         : stall_count, mem_timeout, state_dbg (current sequencer state)
interface hazard_stall_controller_if #(
    parameter int CNT_W = 16
);
    import hazard_pkg::*;

    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic [4:0]       ex_rt;
    logic             ex_mem_read;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             stat_clr;

    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_write;
    logic             idex_bubble;
    logic             exmem_write;
    logic             memwb_bubble;
    logic [CNT_W-1:0] stall_count;
    logic             mem_timeout;
    state_t           state_dbg;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_rt, ex_mem_read, branch_taken,
               mem_req, mem_ready, stat_clr,
        input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
               exmem_write, memwb_bubble, stall_count, mem_timeout, state_dbg
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_rt, ex_mem_read, branch_taken,
               mem_req, mem_ready, stat_clr,
        output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
               exmem_write, memwb_bubble, stall_count, mem_timeout, state_dbg
    );

endinterface

// File: rtl/load_use_detector.sv
// Combinational load-use hazard detect: the load in EX writes a register the
// instruction in ID reads, and forwarding cannot supply it in time.
//   ex_mem_read_i, ex_rt_i         : load in EX and its destination
//   id_rs_i, id_rt_i, id_uses_rt_i : sources of the ID instruction
//   load_use_o                     : hazard present
module load_use_detector
    import hazard_pkg::*;
(
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rt_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rt_i,
    output logic       load_use_o
);

    // Loads into $zero are discarded, so they never create a dependency.
    assign load_use_o = ex_mem_read_i && (ex_rt_i != REG_ZERO) &&
                        ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard sequencer for the 5-stage core: load-use stalls, taken-branch
// flushes and data-memory wait states, plus a saturating stall-cycle counter
// and a sticky memory-timeout flag.
//   clk, reset : clock and asynchronous active-high reset
//   hif        : hazard sources in, pipeline controls and status out
module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    hazard_stall_controller_if.slave hif
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    state_t           state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    action_t          act;
    logic             load_use;
    logic             pc_write_raw;

    load_use_detector u_lud (
        .ex_mem_read_i (hif.ex_mem_read),
        .ex_rt_i       (hif.ex_rt),
        .id_rs_i       (hif.id_rs),
        .id_rt_i       (hif.id_rt),
        .id_uses_rt_i  (hif.id_uses_rt),
        .load_use_o    (load_use)
    );

    // Next-state / action selection. Priority: mem wait > branch > load-use.
    always_comb begin
        act       = ACT_NONE;
        wait_d    = '0;
        timeout_d = timeout_q;
        if (state_q == MEM_WAIT) begin
            if (!hif.mem_ready) begin
                if (wait_q < WAIT_W'(MAX_WAIT)) begin
                    act    = ACT_FREEZE;
                    wait_d = wait_q + WAIT_W'(1);
                end else begin
                    // Access aborted: release the pipeline and flag it.
                    timeout_d = 1'b1;
                end
            end else if (hif.branch_taken) begin
                act = ACT_FLUSH;
            end else if (load_use) begin
                // EX was held during the wait, so the hazard is re-evaluated here.
                act = ACT_STALL;
            end
        end else begin
            if (hif.mem_req && !hif.mem_ready) begin
                act    = ACT_FREEZE;
                wait_d = WAIT_W'(1);
            end else if (hif.branch_taken) begin
                act = ACT_FLUSH;
            // After a stall the load has moved on to MEM; after a flush ID holds a nop.
            end else if (load_use && (state_q == RUN)) begin
                act = ACT_STALL;
            end
        end

        case (act)
            ACT_FREEZE: state_d = MEM_WAIT;
            ACT_FLUSH:  state_d = FLUSH;
            ACT_STALL:  state_d = LOAD_STALL;
            default:    state_d = RUN;
        endcase
    end

    // Output decode; everything is held low while reset is asserted.
    always_comb begin
        pc_write_raw     = 1'b1;
        hif.ifid_write   = 1'b1;
        hif.ifid_flush   = 1'b0;
        hif.idex_write   = 1'b1;
        hif.idex_bubble  = 1'b0;
        hif.exmem_write  = 1'b1;
        hif.memwb_bubble = 1'b0;
        case (act)
            ACT_FREEZE: begin
                pc_write_raw     = 1'b0;
                hif.ifid_write   = 1'b0;
                hif.idex_write   = 1'b0;
                hif.exmem_write  = 1'b0;
                hif.memwb_bubble = 1'b1;
            end
            ACT_FLUSH: begin
                hif.ifid_flush  = 1'b1;
                hif.idex_bubble = 1'b1;
            end
            ACT_STALL: begin
                pc_write_raw    = 1'b0;
                hif.ifid_write  = 1'b0;
                hif.idex_bubble = 1'b1;
            end
            default: ;
        endcase
        hif.pc_write = pc_write_raw;
        if (reset) begin
            hif.pc_write     = 1'b0;
            hif.ifid_write   = 1'b0;
            hif.ifid_flush   = 1'b0;
            hif.idex_write   = 1'b0;
            hif.idex_bubble  = 1'b0;
            hif.exmem_write  = 1'b0;
            hif.memwb_bubble = 1'b0;
        end
    end

    // Clear wins over the increment; the count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (hif.stat_clr) begin
            cnt_d = '0;
        end else if (!pc_write_raw && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            wait_q    <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign hif.stall_count = cnt_q;
    assign hif.mem_timeout = timeout_q;
    assign hif.state_dbg   = state_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;
    import hazard_pkg::*;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 4;
    localparam int W        = 7 + CNT_W + 1 + 2;

    // Control vector order: pc, ifid_w, ifid_flush, idex_w, idex_bubble, exmem_w, memwb_bubble
    localparam logic [6:0] C_NORMAL = 7'b1101010;
    localparam logic [6:0] C_FREEZE = 7'b0000001;
    localparam logic [6:0] C_FLUSH  = 7'b1111110;
    localparam logic [6:0] C_STALL  = 7'b0001110;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    hazard_stall_controller_if #(.CNT_W(CNT_W)) hif ();

    hazard_stall_controller #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .hif   (hif)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks how many consecutive frozen cycles the current access has had,
    // whether the previous cycle was a stall/flush (load-use masked), the
    // stall total and the timeout flag. Pushes the expected outputs each cycle.
    logic [W-1:0] exp_q[$];
    int   m_frozen = 0;
    bit   m_mask   = 0;
    int   m_cnt    = 0;
    bit   m_to     = 0;
    int   m_state  = 0;

    always @(negedge clk) begin
        logic       lu;
        logic [6:0] ctl;
        int         nxt_state;
        bit         abort;
        lu = hif.ex_mem_read && (hif.ex_rt != 5'd0) &&
             ((hif.ex_rt == hif.id_rs) || (hif.id_uses_rt && (hif.ex_rt == hif.id_rt)));
        if (reset) begin
            exp_q.push_back({7'b0, CNT_W'(0), 1'b0, 2'd0});
            m_frozen = 0; m_mask = 0; m_cnt = 0; m_to = 0; m_state = 0;
        end else begin
            abort = 0;
            if (m_frozen > 0 && !hif.mem_ready) begin
                if (m_frozen < MAX_WAIT) ctl = C_FREEZE;
                else begin ctl = C_NORMAL; abort = 1; end
            end else if (m_frozen == 0 && hif.mem_req && !hif.mem_ready) ctl = C_FREEZE;
            else if (hif.branch_taken) ctl = C_FLUSH;
            else if (lu && (m_frozen > 0 || !m_mask)) ctl = C_STALL;
            else ctl = C_NORMAL;

            exp_q.push_back({ctl, CNT_W'(m_cnt), m_to, 2'(m_state)});

            nxt_state = (ctl == C_FREEZE) ? 3 : (ctl == C_FLUSH) ? 2 : (ctl == C_STALL) ? 1 : 0;
            m_frozen  = (ctl == C_FREEZE) ? m_frozen + 1 : 0;
            m_mask    = (ctl == C_FLUSH) || (ctl == C_STALL);
            if (abort) m_to = 1;
            if (hif.stat_clr) m_cnt = 0;
            else if (!ctl[6] && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            m_state = nxt_state;
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [W-1:0] a;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {hif.pc_write, hif.ifid_write, hif.ifid_flush, hif.idex_write,
                 hif.idex_bubble, hif.exmem_write, hif.memwb_bubble,
                 hif.stall_count, hif.mem_timeout, 2'(hif.state_dbg)};
            chk("cycle_outputs", 32'(a), 32'(e));
        end
    end

    // ---------------- driver ----------------
    task automatic cyc(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic [4:0] ert, input logic emr, input logic br,
                       input logic mreq, input logic mrdy, input logic clr);
        @(posedge clk);
        #1;
        hif.id_rs = rs; hif.id_rt = rt; hif.id_uses_rt = urt;
        hif.ex_rt = ert; hif.ex_mem_read = emr; hif.branch_taken = br;
        hif.mem_req = mreq; hif.mem_ready = mrdy; hif.stat_clr = clr;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset = 1'b1;
        hif.id_rs = '0; hif.id_rt = '0; hif.id_uses_rt = 1'b0;
        hif.ex_rt = '0; hif.ex_mem_read = 1'b0; hif.branch_taken = 1'b0;
        hif.mem_req = 1'b0; hif.mem_ready = 1'b0; hif.stat_clr = 1'b0;

        idle();
        chk("reset_pc_write", hif.pc_write, 0);
        chk("reset_ifid_write", hif.ifid_write, 0);
        chk("reset_count", hif.stall_count, 0);
        chk("reset_state", hif.state_dbg, 0);
        @(posedge clk); #1; reset = 1'b0;
        idle();
        chk("run_default_pc", hif.pc_write, 1);

        // 1: lw $5 in EX, ID reads $5 via rs
        cyc(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_pc_write", hif.pc_write, 0);
        chk("t1_ifid_write", hif.ifid_write, 0);
        chk("t1_idex_bubble", hif.idex_bubble, 1);
        cyc(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_masked_pc", hif.pc_write, 1);
        chk("t1_count", hif.stall_count, 1);
        chk("t1_state_ls", hif.state_dbg, 1);
        idle();
        chk("t1_state_run", hif.state_dbg, 0);

        // 2: $zero load and rt match without rt use are not hazards
        cyc(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_zero_pc", hif.pc_write, 1);
        cyc(5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_rt_unused_pc", hif.pc_write, 1);
        cyc(5'd3, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_rt_used_pc", hif.pc_write, 0);
        idle();

        // 3: branch beats load-use, then load-use masked in FLUSH
        cyc(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t3_flush", hif.ifid_flush, 1);
        chk("t3_bubble", hif.idex_bubble, 1);
        chk("t3_pc", hif.pc_write, 1);
        cyc(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_state_flush", hif.state_dbg, 2);
        chk("t3_masked_pc", hif.pc_write, 1);
        chk("t3_count", hif.stall_count, 2);

        // 4: three wait cycles then ready
        cyc(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            chk("t4_frozen_pc", hif.pc_write, 0);
            chk("t4_memwb_bubble", hif.memwb_bubble, 1);
        end
        cyc(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t4_release_pc", hif.pc_write, 1);
        chk("t4_count", hif.stall_count, 3);

        // 5: memory never ready -> abort after MAX_WAIT frozen cycles
        for (int i = 0; i < 4; i++) begin
            cyc(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            chk("t5_frozen_pc", hif.pc_write, 0);
        end
        cyc(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t5_abort_pc", hif.pc_write, 1);
        chk("t5_abort_bubble", hif.memwb_bubble, 0);
        idle();
        chk("t5_timeout", hif.mem_timeout, 1);
        chk("t5_state_run", hif.state_dbg, 0);
        idle();
        chk("t5_timeout_sticky", hif.mem_timeout, 1);

        // 6: saturation, clear beats stall, reset mid-wait
        for (int i = 0; i < 25; i++)
            cyc(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        chk("t6_saturated", hif.stall_count, 15);
        cyc(5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t6_clr_stall_pc", hif.pc_write, 0);
        idle();
        chk("t6_clr_count", hif.stall_count, 0);
        cyc(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t6_state_wait", hif.state_dbg, 3);
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk); #1;
        chk("t6_rst_pc", hif.pc_write, 0);
        chk("t6_rst_memwb", hif.memwb_bubble, 0);
        chk("t6_rst_exmem", hif.exmem_write, 0);
        chk("t6_rst_state", hif.state_dbg, 0);
        chk("t6_rst_timeout", hif.mem_timeout, 0);
        @(posedge clk); #1; reset = 1'b0; hif.mem_req = 1'b0;
        @(negedge clk); #1;
        chk("t6_after_rst_pc", hif.pc_write, 1);

        // Mixed traffic, checked by the model only
        for (int i = 0; i < 60; i++)
            cyc(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 15) == 0));
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
